// File: rtl/jk_ff.sv
// Bank of WIDTH independent positive-edge JK flip-flops with async active-low reset and complementary outputs.
// Latency: one clk edge from j/k to q; qbar is combinational from the same state register.
// No backpressure; optional clock enable ce is compiled in with JKFF_CE_EN (ce=0 holds every bit).
module jk_ff #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic             rst_n
`ifdef JKFF_CE_EN
    ,
    input  logic             ce
`endif
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             upd_en;

`ifdef JKFF_CE_EN
    assign upd_en = ce;
`else
    assign upd_en = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (upd_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b00:   state_d[i] = state_q[i];
                    2'b01:   state_d[i] = 1'b0;
                    2'b10:   state_d[i] = 1'b1;
                    default: state_d[i] = ~state_q[i];
                endcase
            end
        end
    end

    // Explicit compare so a floating (z/x) rst_n never acts as reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == 1'b0) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q    = state_q;
    assign qbar = ~state_q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed-vector bench for a 4-bit jk_ff bank; builds with or without JKFF_CE_EN.
module tb_jk_ff;

    localparam int W = 4;

    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         clk;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         rst_n;
`ifdef JKFF_CE_EN
    logic         ce;
`endif

    int n_checks;
    int n_fails;

    jk_ff #(.WIDTH(W)) dut (
        .j    (j),
        .k    (k),
        .clk  (clk),
        .q    (q),
        .qbar (qbar),
        .rst_n(rst_n)
`ifdef JKFF_CE_EN
        ,
        .ce   (ce)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Drive j/k, take one rising edge, sample 1ns later and check both outputs.
    task automatic apply(input string tag, input logic [W-1:0] jv, input logic [W-1:0] kv,
                         input logic [W-1:0] exp);
        j = jv;
        k = kv;
        @(posedge clk);
        #1;
        check_eq(tag, q, exp);
        check_eq({tag, "_qbar"}, qbar, ~exp);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b1;
        j        = '1;
        k        = '1;
`ifdef JKFF_CE_EN
        ce       = 1'b1;
`endif

        // 1: reset asserted between edges takes effect immediately, holds with clk running
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_q", q, 4'b0000);
        check_eq("rst_async_qbar", qbar, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_q", q, 4'b0000);
            check_eq("rst_hold_qbar", qbar, 4'b1111);
        end
        j = '0;
        k = '0;
        rst_n = 1'b1;

        // 2: hold from 0, then set
        apply("hold0_a", 4'b0000, 4'b0000, 4'b0000);
        apply("hold0_b", 4'b0000, 4'b0000, 4'b0000);
        apply("set",     4'b1111, 4'b0000, 4'b1111);

        // 3: from q=1, sequence 00,01,10,11
        apply("seq_hold",   4'b0000, 4'b0000, 4'b1111);
        apply("seq_clr",    4'b0000, 4'b1111, 4'b0000);
        apply("seq_set",    4'b1111, 4'b0000, 4'b1111);
        apply("seq_toggle", 4'b1111, 4'b1111, 4'b0000);

        // 4: toggle four times from 0
        apply("tog1", 4'b1111, 4'b1111, 4'b1111);
        apply("tog2", 4'b1111, 4'b1111, 4'b0000);
        apply("tog3", 4'b1111, 4'b1111, 4'b1111);
        apply("tog4", 4'b1111, 4'b1111, 4'b0000);

        // 5: mid-cycle reset pulse while q=1
        apply("pre_rst_set", 4'b1111, 4'b0000, 4'b1111);
        j = '0;
        k = '0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_q", q, 4'b0000);
        check_eq("mid_rst_qbar", qbar, 4'b1111);
        #1 rst_n = 1'b1;
        #1;
        check_eq("mid_rst_rel_q", q, 4'b0000);

        // 6: per-bit independence: preload 0011, then mixed ops
        apply("preload", 4'b0011, 4'b1100, 4'b0011);
        apply("mixed",   4'b1010, 4'b0110, 4'b1001);
        apply("mixed2",  4'b0101, 4'b0011, 4'b1100);

`ifdef JKFF_CE_EN
        apply("preload_ce", 4'b0011, 4'b1100, 4'b0011);
        ce = 1'b0;
        apply("ce0_mixed",  4'b1010, 4'b0110, 4'b0011);
        apply("ce0_toggle", 4'b1111, 4'b1111, 4'b0011);
        ce = 1'b1;
        apply("ce1_mixed",  4'b1010, 4'b0110, 4'b1001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
